// File: rtl/data_reg_16b.sv
// Edge-triggered pipeline holding register; optional stall input under DATA_REG_STALL_EN.
// Latency: one rising edge from data_in to data_out. Backpressure: none; stall (if built) holds.
// Reset is asynchronous active-low and overrides stall.
module data_reg_16b #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef DATA_REG_STALL_EN
  input  logic             stall,
`endif
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic load_en;

`ifdef DATA_REG_STALL_EN
  assign load_en = ~stall;
`else
  assign load_en = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
    end else if (load_en) begin
      data_out <= data_in;
    end
  end

endmodule

// File: tb/tb_data_reg_16b.sv
// Self-checking bench for data_reg_16b: directed sequences, a vector table and a randomized model.
module tb_data_reg_16b;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic [15:0] data_in;
  logic [15:0] data_out;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef DATA_REG_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  data_reg_16b dut (
    .clock    (clock),
    .reset_n  (reset_n),
`ifdef DATA_REG_STALL_EN
    .stall    (stall),
`endif
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] expect_q;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] exp);
    tests_run++;
    if (data_out !== exp) begin
      tests_failed++;
      $display("FAIL %s: data_out=%h expected=%h at %0t", name, data_out, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] model;
  logic        rst_r;
  logic        st_r;
  logic [15:0] d_r;

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    data_in = 16'h1234;

    // Reset held for 100 ns with a running clock and non-zero input.
    #1;
    check("reset_initial", 16'h0000);
    for (int i = 0; i < 10; i++) begin
      step();
      check("reset_held", 16'h0000);
    end

    // Release away from the edge with zero input.
    reset_n = 1'b1;
    data_in = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("zero_capture", 16'h0000);
    end

    // Mid-cycle change must not show until the next rising edge.
    #3;
    data_in = 16'd27;
    #1;
    check("mid_cycle_hold", 16'h0000);
    step();
    check("capture_27", 16'h001B);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stable_27", 16'h001B);
    end

    // Vector table: each value appears one edge after it is applied.
    vecs.push_back('{16'hFFFF, 16'hFFFF, "all_ones"});
    vecs.push_back('{16'h8000, 16'h8000, "msb_only"});
    vecs.push_back('{16'h0001, 16'h0001, "lsb_only"});
    vecs.push_back('{16'hA5A5, 16'hA5A5, "pattern_a5"});
    vecs.push_back('{16'h5A5A, 16'h5A5A, "pattern_5a"});
    vecs.push_back('{16'h0000, 16'h0000, "back_to_zero"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, "minus_one"});
    for (int i = 0; i < vecs.size(); i++) begin
      data_in = vecs[i].din;
      step();
      check(vecs[i].name, vecs[i].expect_q);
    end

    // Toggle data_in between edges, including across the falling edge.
    for (int i = 0; i < 4; i++) begin
      data_in = 16'h0F0F;
      #2;
      data_in = 16'hF0F0;
      #4;
      data_in = 16'h3C3C;
      #1;
      check("toggle_hold", 16'hFFFF);
      data_in = 16'hFFFF;
      step();
      check("toggle_edge", 16'hFFFF);
    end

    // Asynchronous reset between edges takes effect without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 16'h0000);
    data_in = 16'h1234;
    step();
    check("edge_in_reset", 16'h0000);
    reset_n = 1'b1;
    data_in = 16'h00A5;
    #1;
    check("release_hold", 16'h0000);
    step();
    check("after_release", 16'h00A5);

    // Reset asserted on the rising edge itself: reset wins.
    data_in = 16'h7777;
    @(posedge clock);
    reset_n = 1'b0;
    #1;
    check("reset_at_edge", 16'h0000);
    step();
    reset_n = 1'b1;
    step();
    check("after_edge_reset", 16'h7777);

`ifdef DATA_REG_STALL_EN
    // Stall holds the current value; reset still overrides it.
    data_in = 16'h0055;
    step();
    check("stall_load", 16'h0055);
    stall   = 1'b1;
    data_in = 16'h0AAA;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 16'h0055);
    end
    stall = 1'b0;
    step();
    check("stall_release", 16'h0AAA);
    stall = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("stall_reset", 16'h0000);
    reset_n = 1'b1;
    step();
    check("stall_after_reset", 16'h0000);
    stall = 1'b0;
    step();
    check("unstall_capture", 16'h0AAA);
`endif

    // Randomized run: the register holds whatever was present at the last
    // rising edge with reset high (and stall low), or zero after any reset.
    data_in = 16'h0000;
    stall   = 1'b0;
    step();
    model = 16'h0000;
    check("rand_start", model);
    for (int i = 0; i < 300; i++) begin
      rst_r = ($urandom_range(0, 9) == 0);
      st_r  = STALL_EN && ($urandom_range(0, 3) == 0);
      d_r   = 16'($urandom);
      reset_n = ~rst_r;
      stall   = st_r;
      data_in = d_r;
      #2;
      if (rst_r) model = 16'h0000;
      check("rand_between_edges", model);
      @(posedge clock);
      if (rst_r) model = 16'h0000;
      else if (!st_r) model = d_r;
      #1;
      check("rand_after_edge", model);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_reg_16b.md
Name: data_reg_16b

Overview:
- Single-stage, edge-triggered data register; default width 16 bits.
- Used as a pipeline/interstage holding register in the datapath (e.g. between ALU/memory stages).
- Captures data_in on every rising clock edge and presents it on data_out until the next edge.
- No handshake; always loads unless the optional stall feature is compiled in and asserted.

Parameters:
- WIDTH, 16, data path width in bits (must be >= 1).
- RESET_VALUE, {WIDTH{1'b0}}, value forced onto data_out while reset_n is low.

Ports:
- clock  input  1  system clock; all capture on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  data to capture.
- data_out  output  WIDTH  registered copy of data_in.

Behaviour:
- Reset: asynchronous and active-low. While reset_n = 0, data_out = RESET_VALUE (0x0000 by default) immediately, independent of clock.
- Reset release: first capture occurs on the first rising clock edge after reset_n returns to 1. No synchronous release logic is included inside the block; the reset source is responsible for deasserting synchronously to clock.
- Capture: on each rising edge of clock with reset_n = 1, data_out <= data_in. Latency is exactly one clock edge.
- Hold: between rising edges, data_out must not change, even when data_in toggles. The falling edge has no effect.
- Data handling:
  - Bit-exact transfer with no sign or zero extension and no arithmetic.
  - Treated as unsigned bits, so data_in = -1 (0xFFFF) appears as all ones.
- Reset mid-operation: asserting reset_n while clock is running forces data_out to RESET_VALUE within the same delta. Rising edges during reset are ignored.
- Simultaneous reset and rising edge: reset wins; data_out = RESET_VALUE.
- Power-up before any reset or edge: data_out is undefined. The system must apply reset before data_out is consumed.
- No internal state other than the WIDTH-bit register.

Optional Feature:
- Macro: DATA_REG_STALL_EN.
- Defined:
  - Adds input port stall (1 bit, active-high), placed after reset_n.
  - On a rising edge with stall = 1, data_out holds its current value.
  - With stall = 0, the register captures as normal.
  - Reset still overrides stall.
- Not defined:
  - No stall port exists.
  - The register captures on every rising edge, as described in Behaviour.

Test Plan:
- Hold reset_n = 0 for 100 ns with data_in = 0x1234 and clock running -> data_out = 0x0000 throughout.
- Release reset, data_in = 0, run 5 edges -> data_out = 0x0000 (binary 0000000000000000).
- Set data_in = 27 mid-cycle -> data_out still 0x0000 before the next rising edge; 0x001B (0000000000011011) after it, stable for the remaining cycles.
- Set data_in = 16'hFFFF (-1) -> data_out = 1111111111111111 after the next rising edge. Toggle data_in between edges -> data_out changes only at rising edges.
- With data_out = 0xFFFF, pull reset_n low between edges -> data_out = 0x0000 immediately, without waiting for a clock edge. Release, data_in = 0x00A5 -> data_out = 0x00A5 after the next rising edge.
- With DATA_REG_STALL_EN defined: load 0x0055, then stall = 1 with data_in = 0x0AAA for 3 edges -> data_out stays 0x0055. Set stall = 0 -> data_out = 0x0AAA after the next edge.
